// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the 7-segment
// display-bus capture block.
package seg_scan_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    COLLECT,
    PUBLISH
  } state_t;

  // Index i holds the strict g..a pattern for digit i.
  localparam logic [9:0][6:0] SEG_PATTERNS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [2:0] SLOT_SEP1 = 3'd2;
  localparam logic [2:0] SLOT_SEP2 = 3'd5;

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: strict 7-segment pattern to BCD digit decoder.
// Unknown patterns map to 4'hF with o_invalid set.
module seg7_to_bcd
  import seg_scan_pkg::*;
(
  input  logic [6:0] i_pat,
  output digit_t     o_digit,
  output logic       o_invalid
);

  always_comb begin
    o_digit   = 4'hF;
    o_invalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i_pat == SEG_PATTERNS[i]) begin
        o_digit   = digit_t'(i);
        o_invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive side of a multiplexed 8-digit 7-seg bus.
// Filters, decodes and assembles HH:MM:SS frames with validity flags.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 150000,
  parameter bit CS_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cs,
  input  logic [7:0] seg,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       frame_valid,
  output logic       time_ok,
  output logic       seg_err,
  output logic       cs_err,
  output logic       stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CMAX =
    CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CS_IDLE =
    CS_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] SEG_IDLE =
    SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0]    r_cs_s1, r_cs_s2;
  logic [7:0]    r_seg_s1, r_seg_s2;
  logic [7:0]    w_cs, w_seg;
  logic [7:0]    r_prev_cs, r_prev_seg;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          w_accept;

  digit_t        w_digit;
  logic          w_invalid;
  logic [2:0]    w_idx;
  logic          w_multi, w_one, w_sep, w_store;

  digit_t        r_slot [8];
  logic [7:0]    r_seen;
  logic          r_bad;
  logic [TW-1:0] r_to;
  logic          w_complete, w_timeout;

  state_t        r_state, w_next;
  logic [6:0]    w_hh7, w_mm7, w_ss7;
  logic          w_ok;

  logic [4:0]    r_hh;
  logic [5:0]    r_mm, r_ss;
  logic          r_ok, r_seg_err;
  logic          r_cs_err, r_stale;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_s1  <= CS_IDLE;
      r_cs_s2  <= CS_IDLE;
      r_seg_s1 <= SEG_IDLE;
      r_seg_s2 <= SEG_IDLE;
    end else begin
      r_cs_s1  <= cs;
      r_cs_s2  <= r_cs_s1;
      r_seg_s1 <= seg;
      r_seg_s2 <= r_seg_s1;
    end
  end

  assign w_cs  = CS_ACTIVE_LOW  ? ~r_cs_s2  : r_cs_s2;
  assign w_seg = SEG_ACTIVE_LOW ? ~r_seg_s2 : r_seg_s2;

  // r_done blocks re-acceptance of a pair that is still held.
  assign w_accept = (r_cnt == CMAX) && !r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_cs  <= '0;
      r_prev_seg <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_prev_cs  <= w_cs;
      r_prev_seg <= w_seg;
      if (w_cs != r_prev_cs ||
          w_seg != r_prev_seg) begin
        r_cnt  <= '0;
        r_done <= 1'b0;
      end else begin
        if (r_cnt != CMAX) r_cnt <= r_cnt + 1'b1;
        if (w_accept) r_done <= 1'b1;
      end
    end
  end

  seg7_to_bcd u_dec (
    .i_pat     (r_prev_seg[6:0]),
    .o_digit   (w_digit),
    .o_invalid (w_invalid)
  );

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_prev_cs[i]) w_idx = 3'(i);
    end
  end

  assign w_multi = |(r_prev_cs & (r_prev_cs - 8'd1));
  assign w_one   = (r_prev_cs != 8'd0) && !w_multi;
  assign w_sep   = (w_idx == SLOT_SEP1) ||
                   (w_idx == SLOT_SEP2);
  assign w_store = w_accept && w_one;

  assign w_complete = (r_state == COLLECT) &&
                      (r_seen == 8'hFF);
  assign w_timeout  = !w_complete && !w_store &&
                      (r_seen != 8'd0) && (r_to == TMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_slot[i] <= '0;
    end else if (w_store) begin
      r_slot[w_idx] <= w_digit;
    end
  end

  // A store in the publish cycle lands after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen  <= '0;
      r_bad   <= 1'b0;
      r_to    <= '0;
      r_stale <= 1'b0;
    end else begin
      if (w_complete || w_timeout) begin
        r_seen <= '0;
        r_bad  <= 1'b0;
      end
      if (w_store) begin
        r_seen[w_idx] <= 1'b1;
        if (w_invalid && !w_sep) r_bad <= 1'b1;
      end
      if (w_store || w_complete || w_timeout ||
          r_seen == 8'd0) begin
        r_to <= '0;
      end else if (r_to != TMAX) begin
        r_to <= r_to + 1'b1;
      end
      if (w_complete) r_stale <= 1'b0;
      else if (w_timeout) r_stale <= 1'b1;
    end
  end

  assign w_hh7 = 7'(r_slot[0]) * 7'd10 + 7'(r_slot[1]);
  assign w_mm7 = 7'(r_slot[3]) * 7'd10 + 7'(r_slot[4]);
  assign w_ss7 = 7'(r_slot[6]) * 7'd10 + 7'(r_slot[7]);
  assign w_ok  = !r_bad && (w_hh7 <= 7'd23) &&
                 (w_mm7 <= 7'd59) && (w_ss7 <= 7'd59);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hh      <= '0;
      r_mm      <= '0;
      r_ss      <= '0;
      r_ok      <= 1'b0;
      r_seg_err <= 1'b0;
      r_cs_err  <= 1'b0;
    end else begin
      if (w_complete) begin
        r_hh      <= w_hh7[4:0];
        r_mm      <= w_mm7[5:0];
        r_ss      <= w_ss7[5:0];
        r_ok      <= w_ok;
        r_seg_err <= r_bad;
      end
      if (w_accept && w_multi) r_cs_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    frame_valid = 1'b0;
    unique case (r_state)
      COLLECT: begin
        if (r_seen == 8'hFF) w_next = PUBLISH;
      end
      PUBLISH: begin
        frame_valid = 1'b1;
        w_next      = COLLECT;
      end
      default: w_next = COLLECT;
    endcase
  end

  assign hh      = r_hh;
  assign mm      = r_mm;
  assign ss      = r_ss;
  assign time_ok = r_ok;
  assign seg_err = r_seg_err;
  assign cs_err  = r_cs_err;
  assign stale   = r_stale;

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive end of the multiplexed 8-digit seven-segment display bus that the digital clock drives.
- Samples the digit-select and segment lines, filters transition glitches, and decodes each lit digit back to BCD.
- Assembles a full HH:MM:SS frame and reports the time with validity flags.
- Used as an on-board display monitor and as a self-check capture for the clock's display path.

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples required before a (cs, seg) pair is accepted.
- TIMEOUT_CYCLES, 150000: maximum cycles between accepted digits before the partial frame is discarded.
- CS_ACTIVE_LOW, 1: 1 = digit select lines are active-low.
- SEG_ACTIVE_LOW, 1: 1 = segment lines are active-low.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cs  in  8  digit select; cs[0] = leftmost digit (hours tens)
- seg  in  8  segments; bit7 = dp, bits6:0 = g..a
- hh  out  5  captured hours
- mm  out  6  captured minutes
- ss  out  6  captured seconds
- frame_valid  out  1  one-cycle pulse when a complete frame is published
- time_ok  out  1  last published frame fully legal
- seg_err  out  1  last frame contained an undecodable digit
- cs_err  out  1  sticky: multi-hot select seen; cleared by rst only
- stale  out  1  timeout occurred since the last published frame

Behaviour:
- Reset (rst high at a clk edge): all outputs 0, seen mask 0, filter counter 0, synchronizers cleared to the inactive level.
- Input path: 2-flop synchronizer on cs and seg, then normalize polarity per the parameters so that 1 means active internally.
- Stability filter:
  - Count up while the normalized pair equals the previous cycle's pair; restart at 0 on any change.
  - The pair is accepted exactly once when the count reaches STABLE_CYCLES-1.
  - No re-acceptance occurs until the pair changes.
- On acceptance:
  - cs all-zero: ignored; no state change.
  - cs multi-hot: set cs_err; digit discarded.
  - cs one-hot, index k: decode seg[6:0] with strict patterns 0x3F,06,5B,4F,66,6D,7D,07,7F,6F -> 0..9. Any other pattern -> 4'hF and mark the frame bad.
  - Store the value in slot k, set seen[k], reload the timeout counter.
  - A repeated slot before frame completion overwrites the earlier value.
- Slots 2 and 5 are separators:
  - They must be seen, but their content and dp are ignored.
  - They never mark the frame bad.
- Frame completion: the cycle after seen == 8'hFF:
  - hh = d0*10+d1, mm = d3*10+d4, ss = d6*10+d7. Compute in 7-bit arithmetic, then truncate; if any digit is 4'hF the fields are don't-care.
  - time_ok = no bad digit AND hh<=23 AND mm<=59 AND ss<=59.
  - seg_err = bad digit present.
  - frame_valid pulses for 1 cycle.
  - seen and the bad flag clear; stale clears.
  - Outputs hold until the next frame.
- Latency: last digit stable at the pins -> frame_valid = 2 (sync) + STABLE_CYCLES + 2 cycles.
- Timeout: if no acceptance within TIMEOUT_CYCLES while seen != 0, clear seen and the bad flag and set stale. Published outputs are unchanged.
- Simultaneous events: completion and timeout in the same cycle -> completion wins.
- rst mid-frame discards everything, including cs_err.

Decomposition:
- Package seg_scan_pkg:
  - SEG_PATTERNS[10] constant.
  - SLOT_SEP1=2, SLOT_SEP2=5 constants.
  - typedef digit_t (logic [3:0]).
- Sub-module seg7_to_bcd: combinational 7-bit pattern -> digit_t plus invalid flag.
- Filter, slot storage, timeout counter and frame FSM (COLLECT, PUBLISH) stay in the top.

Test Plan:
- Scan 1,2,x,3,4,x,5,6 (active-low, each digit held 200 cycles) -> frame_valid once; hh=12, mm=34, ss=56; time_ok=1; seg_err=0.
- Hold 50 cycles of glitch (cs changes every 3 cycles) between digits -> no extra acceptance; result identical to the clean scan.
- Digit slot 4 driven with seg=0x49 (normalized) -> frame_valid; seg_err=1; time_ok=0.
- Frame 2,5,x,0,0,x,0,0 -> hh=25, time_ok=0, seg_err=0.
- Scan 3 digits then idle 150001 cycles -> stale=1, no frame_valid; a following full scan 23:59:59 -> time_ok=1, stale=0.
- cs=0x03 (normalized) held 20 cycles -> cs_err=1 and persists across later good frames; assert rst mid-frame -> all outputs 0 the next cycle.
